// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch/condition front end: condition codes, PC update
// modes, PSR bit positions and the opcode values that select the Scond form.
package fetch_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] PC_HOLD       = 2'b00;
    localparam logic [1:0] PC_RESET      = 2'b01;
    localparam logic [1:0] PC_JUMP       = 2'b10;
    localparam logic [1:0] PC_STEP_OR_BR = 2'b11;

    // PSR packed as {C,L,F,Z,N}
    localparam int unsigned PSR_C = 4;
    localparam int unsigned PSR_L = 3;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 1;
    localparam int unsigned PSR_N = 0;

    localparam logic [3:0] OP_REGX   = 4'b0100;
    localparam logic [3:0] EXT_SCOND = 4'b1101;

endpackage

// File: rtl/fetch_cond_unit_cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// holds against the {C,L,F,Z,N} flag vector.
module cond_eval
    import fetch_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_flags,
    output logic       o_condTrue
);

    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = i_flags[PSR_C];
    assign w_l = i_flags[PSR_L];
    assign w_f = i_flags[PSR_F];
    assign w_z = i_flags[PSR_Z];
    assign w_n = i_flags[PSR_N];

    always_comb begin
        o_condTrue = 1'b0;
        unique case (i_cond)
            COND_EQ: o_condTrue = w_z;
            COND_NE: o_condTrue = ~w_z;
            COND_CS: o_condTrue = w_c;
            COND_CC: o_condTrue = ~w_c;
            COND_HI: o_condTrue = w_l;
            COND_LS: o_condTrue = ~w_l;
            COND_GT: o_condTrue = w_n;
            COND_LE: o_condTrue = ~w_n;
            COND_FS: o_condTrue = w_f;
            COND_FC: o_condTrue = ~w_f;
            COND_LO: o_condTrue = ~w_l & ~w_z;
            COND_HS: o_condTrue = w_l | w_z;
            COND_LT: o_condTrue = ~w_n & ~w_z;
            COND_GE: o_condTrue = w_n | w_z;
            COND_UC: o_condTrue = 1'b1;
            COND_NV: o_condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_cond_unit.sv
// Front-end stage: PC, instruction register and PSR, plus field decode and
// branch/set condition evaluation driven into the multicycle controller.
module fetch_cond_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH        = 16,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       PC_STEP      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_memDataIn,
    input  logic             i_instrRegEn,
    input  logic [1:0]       i_pcEn,
    input  logic             i_muxPc,
    input  logic [WIDTH-1:0] i_jumpTarget,
    input  logic             i_codesComputed,
    input  logic             i_aluC,
    input  logic             i_aluL,
    input  logic             i_aluF,
    input  logic             i_aluZ,
    input  logic             i_aluN,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_instr,
    output logic [3:0]       o_opCode,
    output logic [3:0]       o_rDest,
    output logic [3:0]       o_opCodeExt,
    output logic [3:0]       o_rSrc,
    output logic [WIDTH-1:0] o_immSext,
    output logic [WIDTH-1:0] o_conCodesOut,
    output logic [4:0]       o_psrFlags,
    output logic             o_carryIn
);

    localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(PC_STEP);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [4:0]       r_psr;

    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_imm_sext;
    logic [3:0]       w_cond;
    logic             w_is_scond;
    logic             w_cond_true;

    assign w_imm_sext = {{(WIDTH-8){r_instr[7]}}, r_instr[7:0]};

    always_comb begin
        w_pc_next = r_pc;
        unique case (i_pcEn)
            PC_HOLD:       w_pc_next = r_pc;
            PC_RESET:      w_pc_next = RESET_VECTOR;
            PC_JUMP:       w_pc_next = i_jumpTarget;
            PC_STEP_OR_BR: w_pc_next = i_muxPc ? (r_pc + w_imm_sext) : (r_pc + LP_STEP);
        endcase
    end

    // All three registers see pre-edge values, so a branch taken while the IR
    // reloads still uses the old displacement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_psr   <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (i_instrRegEn) begin
                r_instr <= i_memDataIn;
            end
            if (i_codesComputed) begin
                r_psr <= {i_aluC, i_aluL, i_aluF, i_aluZ, i_aluN};
            end
        end
    end

    // Scond carries its condition in the rSrc slot; everything else uses rDest.
    assign w_is_scond = (r_instr[15:12] == OP_REGX) && (r_instr[7:4] == EXT_SCOND);
    assign w_cond     = w_is_scond ? r_instr[3:0] : r_instr[11:8];

    cond_eval u_cond_eval (
        .i_cond     (w_cond),
        .i_flags    (r_psr),
        .o_condTrue (w_cond_true)
    );

    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_opCode      = r_instr[15:12];
    assign o_rDest       = r_instr[11:8];
    assign o_opCodeExt   = r_instr[7:4];
    assign o_rSrc        = r_instr[3:0];
    assign o_immSext     = w_imm_sext;
    assign o_conCodesOut = {{(WIDTH-1){1'b0}}, w_cond_true};
    assign o_psrFlags    = r_psr;
    assign o_carryIn     = r_psr[PSR_C];

endmodule
